// File: rtl/sm_disp_pkg.sv
// Shared state and phase encodings for the sign-magnitude display sequencer.
package sm_disp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_A    = 2'd1;
  localparam state_t ST_B    = 2'd2;
  localparam state_t ST_SUM  = 2'd3;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_A    = 2'b01;
  localparam logic [1:0] PH_B    = 2'b10;
  localparam logic [1:0] PH_SUM  = 2'b11;

  function automatic logic [1:0] phase_of(input state_t st);
    logic [1:0] ph;
    ph = PH_IDLE;
    unique case (1'b1)
      (st == ST_A):   ph = PH_A;
      (st == ST_B):   ph = PH_B;
      (st == ST_SUM): ph = PH_SUM;
      default:        ph = PH_IDLE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, ticks on the last count.
// Holds when disabled; clear or reset forces it back to zero.
module dwell_timer #(
  parameter int DWELL = 50_000_000,
  parameter int CW    = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sm_disp_sched.sv
// Display sequencer: shows operand A, operand B, then the adder sum.
// Optional pause input with SM_DISP_SCHED_PAUSE_EN.
module sm_disp_sched
  import sm_disp_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 50_000_000,
  parameter int CW    = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  input  logic [N-1:0] sum_in,
  output logic [N-1:0] mout,
  output logic [1:0]   phase,
  output logic         done
`ifdef SM_DISP_SCHED_PAUSE_EN
  ,
  input  logic         pause
`endif
);

  state_t state, state_nx;
  logic   run, tick, accept, last, tclr;

`ifdef SM_DISP_SCHED_PAUSE_EN
  assign run = (state != ST_IDLE) && !pause;
`else
  assign run = (state != ST_IDLE);
`endif

  assign accept = in_valid && in_ready && !clr;
  assign last   = (state == ST_SUM) && tick;
  assign tclr   = clr || (state == ST_IDLE);

  dwell_timer #(
    .DWELL (DWELL),
    .CW    (CW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tclr),
    .enable (run),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= last && !clr;
      if (accept) begin
        op_a <= a_in;
        op_b <= b_in;
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (in_valid) state_nx = ST_A;
        ST_A:    if (tick)     state_nx = ST_B;
        ST_B:    if (tick)     state_nx = ST_SUM;
        ST_SUM:  if (tick)     state_nx = ST_IDLE;
        default:               state_nx = ST_IDLE;
      endcase
    end
  end

  // sum_in comes straight from the combinational adder on op_a/op_b
  always_comb begin
    mout     = '0;
    in_ready = 1'b0;
    phase    = phase_of(state);
    unique case (1'b1)
      (state == ST_IDLE): in_ready = 1'b1;
      (state == ST_A):    mout     = op_a;
      (state == ST_B):    mout     = op_b;
      (state == ST_SUM):  mout     = sum_in;
      default:            mout     = '0;
    endcase
  end

endmodule

// File: tb/tb_sm_disp_sched.sv
// Scoreboard bench for sm_disp_sched: display runs are checked by a monitor.
// Pause scenario runs only with SM_DISP_SCHED_PAUSE_EN.
module tb_sm_disp_sched;

  localparam int N     = 4;
  localparam int DWELL = 3;
  localparam int CW    = 4;

  logic         clk = 1'b0;
  logic         reset, clr, in_valid, in_ready, done;
  logic [N-1:0] a_in, b_in, op_a, op_b, sum_in, mout;
  logic [1:0]   phase;
`ifdef SM_DISP_SCHED_PAUSE_EN
  logic         pause;
`endif

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [1:0]   ph;
    logic [N-1:0] m;
    int           len;
    bit           dn;
  } seg_t;

  seg_t exp_q[$];

  always #5 clk = ~clk;

  sm_disp_sched #(
    .N     (N),
    .DWELL (DWELL),
    .CW    (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .op_a     (op_a),
    .op_b     (op_b),
    .sum_in   (sum_in),
    .mout     (mout),
    .phase    (phase),
    .done     (done)
`ifdef SM_DISP_SCHED_PAUSE_EN
    ,
    .pause    (pause)
`endif
  );

  // sign-magnitude adder on the registered operands
  function automatic logic [N-1:0] smadd(input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    int va, vb, s, mag;
    logic [N-1:0] r;
    va = int'(a[N-2:0]);
    vb = int'(b[N-2:0]);
    if (a[N-1]) va = -va;
    if (b[N-1]) vb = -vb;
    s   = va + vb;
    mag = (s < 0) ? -s : s;
    r[N-1]   = (s < 0);
    r[N-2:0] = mag[N-2:0];
    return r;
  endfunction

  always_comb sum_in = smadd(op_a, op_b);

  task automatic push_seg(input logic [1:0] ph, input logic [N-1:0] m,
                          input int len);
    seg_t e;
    e.ph = ph; e.m = m; e.len = len; e.dn = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    seg_t e;
    e.ph = 2'b00; e.m = '0; e.len = -1; e.dn = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] s, input int blen);
    push_seg(2'b01, a, DWELL);
    push_seg(2'b10, b, blen);
    push_seg(2'b11, s, DWELL);
    push_done();
  endtask

  task automatic check_seg(input logic [1:0] ph, input logic [N-1:0] m,
                           input int len, input bit dn);
    seg_t e;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL unexpected_%s: got phase=%b mout=%b len=%0d, required none",
               dn ? "done" : "run", ph, m, len);
      return;
    end
    e = exp_q.pop_front();
    if (e.dn != dn || e.ph != ph || e.m != m ||
        (!dn && e.len >= 0 && e.len != len)) begin
      failed++;
      $display("FAIL scoreboard: got dn=%0d phase=%b mout=%b len=%0d, required dn=%0d phase=%b mout=%b len=%0d",
               dn, ph, m, len, e.dn, e.ph, e.m, e.len);
    end
  endtask

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  logic [1:0]   cur_ph;
  logic [N-1:0] cur_m;
  int           run = 0;

  // monitor: compress the display into runs of equal (phase, mout)
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else begin
      if (run > 0 && (phase != cur_ph || mout != cur_m)) begin
        check_seg(cur_ph, cur_m, run, 1'b0);
        run = 0;
      end
      if (run == 0) begin
        cur_ph = phase;
        cur_m  = mout;
      end
      run++;
      if (done) check_seg(phase, mout, 0, 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int ndone;
    reset    = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b1;
    a_in     = 4'b0011;
    b_in     = 4'b1010;
`ifdef SM_DISP_SCHED_PAUSE_EN
    pause    = 1'b0;
`endif

    // reset with in_valid held high
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", 8'(in_ready), 8'h1);
      check("rst_phase", 8'(phase), 8'h0);
      check("rst_mout", 8'(mout), 8'h0);
      check("rst_op_a", 8'(op_a), 8'h0);
      check("rst_op_b", 8'(op_b), 8'h0);
      check("rst_done", 8'(done), 8'h0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_phase", 8'(phase), 8'h0);
    tick();

    // basic sequence: +3 + -2 = +1
    push_seg(2'b00, 4'b0000, -1);
    push_seq(4'b0011, 4'b1010, 4'b0001, DWELL);
    send(4'b0011, 4'b1010);
    repeat (12) tick();

    // in_valid during SHOW_B is ignored
    push_seg(2'b00, 4'b0000, -1);
    push_seq(4'b0011, 4'b1010, 4'b0001, DWELL);
    send(4'b0011, 4'b1010);
    repeat (3) tick();
    in_valid = 1'b1;
    a_in     = 4'b0111;
    b_in     = 4'b0000;
    repeat (2) tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("midseq_op_a", 8'(op_a), 8'h3);
    check("midseq_op_b", 8'(op_b), 8'ha);
    tick();
    repeat (10) tick();

    // clr in the second cycle of SHOW_A
    push_seg(2'b00, 4'b0000, -1);
    push_seg(2'b01, 4'b0101, 2);
    send(4'b0101, 4'b1100);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("clr_phase", 8'(phase), 8'h0);
    check("clr_in_ready", 8'(in_ready), 8'h1);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("clr_no_done", 8'(ndone), 8'h0);
    tick();

    // clr beats a handshake in IDLE; operands retained
    clr      = 1'b1;
    in_valid = 1'b1;
    a_in     = 4'b0111;
    b_in     = 4'b0001;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_vs_valid_phase", 8'(phase), 8'h0);
    check("clr_keeps_op_a", 8'(op_a), 8'h5);
    tick();

    // back-to-back: accepted in the done cycle, period 10
    push_seg(2'b00, 4'b0000, -1);
    push_seq(4'b0101, 4'b1100, 4'b0001, DWELL);
    push_seg(2'b00, 4'b0000, 1);
    push_seq(4'b0101, 4'b1100, 4'b0001, DWELL);
    in_valid = 1'b1;
    a_in     = 4'b0101;
    b_in     = 4'b1100;
    repeat (11) tick();
    in_valid = 1'b0;
    repeat (12) tick();

`ifdef SM_DISP_SCHED_PAUSE_EN
    // pause for 5 cycles in SHOW_B stretches it to 8
    push_seg(2'b00, 4'b0000, -1);
    push_seq(4'b0011, 4'b1010, 4'b0001, DWELL + 5);
    send(4'b0011, 4'b1010);
    repeat (3) tick();
    pause = 1'b1;
    repeat (5) tick();
    pause = 1'b0;
    repeat (14) tick();
`endif

    repeat (2) tick();
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL leftover: got %0d pending entries, required 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sm_disp_sched.md
Name: sm_disp_sched

Overview:
- Sequencer for the sign-magnitude adder / 7-seg display datapath.
- Accepts an operand pair over a valid/ready handshake and registers it as the adder operands.
- Steps the displayed magnitude through operand A, operand B, then the adder sum, each held for a programmable dwell time; the display mux is driven from its outputs.
- Replaces manual button selection of the displayed value.

Parameters:
- N, 4, operand/sum width in bits (sign-magnitude, MSB = sign); N >= 2.
- DWELL, 50_000_000, clock cycles each display phase lasts; DWELL >= 1.
- CW, 26, dwell counter width; 2**CW >= DWELL.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clr  in  1  synchronous abort of the current sequence.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept an operand pair.
- a_in  in  N  operand A.
- b_in  in  N  operand B.
- op_a  out  N  registered operand A, to adder input a.
- op_b  out  N  registered operand B, to adder input b.
- sum_in  in  N  combinational sum from the adder.
- mout  out  N  value to display; sign = mout[N-1], magnitude = mout[N-2:0].
- phase  out  2  current phase: 00 idle, 01 A, 10 B, 11 sum.
- done  out  1  one-cycle pulse at sequence completion.
- pause  in  1  present only with PAUSE_EN.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values:
  - state IDLE; op_a = 0, op_b = 0; counter = 0.
  - mout = 0, phase = 00, done = 0, in_ready = 1.
- States: IDLE, SHOW_A, SHOW_B, SHOW_SUM. Encoding and phase code come from the package.
- Outputs:
  - in_ready = 1 only in IDLE.
  - mout and phase are combinational decodes of the state: IDLE gives 0; SHOW_A gives op_a; SHOW_B gives op_b; SHOW_SUM gives sum_in.
- Handshake:
  - Accept when in_valid && in_ready at a clock edge.
  - On accept: op_a <= a_in, op_b <= b_in, state <= SHOW_A, counter <= 0.
  - mout = a_in from the following cycle.
  - in_valid outside IDLE is ignored; operands are never altered mid-sequence.
- Dwell:
  - In each SHOW state the counter counts 0..DWELL-1.
  - On DWELL-1: advance state and clear the counter.
  - Each phase lasts exactly DWELL cycles.
  - With DWELL = 1, each phase lasts one cycle.
- Completion:
  - SHOW_SUM end: state <= IDLE, done <= 1 for exactly one cycle, coincident with the first IDLE cycle.
  - A handshake in that cycle is accepted, so back-to-back sequences have no gap beyond the done cycle.
- clr:
  - In any state: next state IDLE, counter 0, no done pulse.
  - op_a/op_b keep their values.
  - clr together with in_valid in IDLE: clr wins and the pair is not accepted.
- Priority: reset > clr > handshake/dwell advance.
- sum_in is used unregistered; the adder is combinational from op_a/op_b, so the sum is valid in SHOW_SUM.

Optional Feature:
- Macro: SM_DISP_SCHED_PAUSE_EN.
- Defined:
  - Adds input pause.
  - While pause = 1 in a SHOW state, the counter holds and the state holds.
  - clr and reset still act.
  - pause in IDLE has no effect and does not block a handshake.
- Undefined: no pause port; the counter always runs in SHOW states.

Decomposition:
- Package sm_disp_pkg:
  - State encoding localparams ST_IDLE, ST_A, ST_B, ST_SUM.
  - Phase codes PH_IDLE = 2'b00, PH_A = 2'b01, PH_B = 2'b10, PH_SUM = 2'b11.
- Sub-module dwell_timer, with ports:
  - clk, reset, clear, enable in.
  - tick out, high on count DWELL-1.
  - Parameters DWELL, CW.
  - The FSM uses tick to advance.

Test Plan (N = 4, DWELL = 3, adder sign_mag_add instantiated in the bench on op_a/op_b):
1. Assert reset for 2 cycles while in_valid = 1 -> in_ready = 1, phase = 00, mout = 0, op_a = op_b = 0, done = 0; nothing accepted.
2. Send a_in = 0011, b_in = 1010 -> three phases of 3 cycles each:
   - phase 01 with mout = 0011;
   - phase 10 with mout = 1010;
   - phase 11 with mout = 0001 (+3 + -2);
   - then a single done pulse with phase = 00.
3. During SHOW_B, drive in_valid = 1 with a_in = 0111 -> ignored; op_a stays 0011; the sequence completes unchanged.
4. Assert clr in the 2nd cycle of SHOW_A -> phase = 00 the next cycle, in_ready = 1, no done pulse during the next 10 cycles.
5. Hold in_valid = 1 continuously with 0101/1100 -> a new pair is accepted in the done cycle and phase = 01 on the following cycle; the repeat period is 10 cycles.
6. With SM_DISP_SCHED_PAUSE_EN defined, hold pause = 1 for 5 cycles during SHOW_B -> phase = 10 for 8 cycles total; total sequence length is 14 cycles.
